ddr_burst_sched: RTL and testbench

- Burst scheduler between the user-side read/write FIFOs and the AXI master engine feeding the MIG DDR3 AXI slave port.
- Decides when a write burst or a read burst is due, arbitrates round-robin when both are eligible, and generates wrapping burst addresses within the configured windows.
- Issues one command at a time over a valid/ready handshake and waits for the engine's completion pulse before it arbitrates again.
- Lives in the ui_clk domain. All inputs are already synchronous to clk.

---
 rtl/ddr_sched_pkg.sv | 49 ++++
 rtl/ddr_addr_wrap.sv | 62 ++++++
 rtl/ddr_burst_sched.sv | 215 +++++++++++++++++++++
 tb/tb_ddr_burst_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
// ddr_sched_pkg
// Shared definitions for the DDR burst scheduler:
//   sched_state_t  - scheduler FSM states (IDLE, ISSUE, WAIT)
//   AXI_BYTES      - bytes per beat for the default 64-bit AXI width
//   AXI_SHIFT      - log2(AXI_BYTES) for the default width
//   axi_shift()    - log2 of bytes per beat for an arbitrary AXI width
//   wrap_next()    - next burst start address with window wrap
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  localparam int AXI_BYTES = 8;
  localparam int AXI_SHIFT = 3;

  function automatic int axi_shift(input int axi_width);
    return $clog2(axi_width / 8);
  endfunction

  // Address arithmetic is done in 34 bits so that both the advanced pointer
  // and the last byte of the following burst are exact for any address
  // width up to 31 bits. A burst that would cross end_a, or a pointer that
  // leaves the addr_w-bit space, restarts at beg: tail fragments shorter
  // than a full burst are never issued.
  function automatic logic [31:0] wrap_next(
    input logic [31:0] ptr,
    input logic [31:0] beg,
    input logic [31:0] end_a,
    input logic [7:0]  len,
    input int          shift,
    input int          addr_w
  );
    logic [33:0] bytes;
    logic [33:0] nxt;
    logic [33:0] last;
    logic [33:0] lim;
    bytes = ({26'd0, len} + 34'd1) << shift;
    nxt   = {2'b00, ptr} + bytes;
    last  = nxt + bytes - 34'd1;
    lim   = 34'd1 << addr_w;
    if ((nxt >= lim) || (last > {2'b00, end_a}))
      return beg;
    return nxt[31:0];
  endfunction

endpackage

// File: rtl/ddr_addr_wrap.sv
// ddr_addr_wrap
// Per-channel burst pointer. Loads beg_addr on init or clr (these win over
// an advance in the same cycle), otherwise steps by one burst on adv and
// wraps back to beg_addr when the next full burst would leave the window.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   init            first cycle after reset release: load beg_addr
//   clr             software reload of the pointer
//   adv             a command from this channel was accepted
//   beg_addr        window start (byte address)
//   end_addr        window last byte, inclusive
//   burst_len       beats minus 1 of the burst being advanced over
//   ptr             current burst start address
module ddr_addr_wrap
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int SHIFT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              clr,
  input  logic              adv,
  input  logic [ADDR_W-1:0] beg_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [7:0]        burst_len,
  output logic [ADDR_W-1:0] ptr
);

  localparam int PAD = 32 - ADDR_W;

  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] ptr_next;
  logic [31:0]       wrapped;
  logic              unused_hi;

  assign wrapped = wrap_next({{PAD{1'b0}}, ptr_reg},
                             {{PAD{1'b0}}, beg_addr},
                             {{PAD{1'b0}}, end_addr},
                             burst_len, SHIFT, ADDR_W);
  // wrap_next never returns anything above the window, so the top bits are zero.
  assign unused_hi = ^wrapped[31:ADDR_W];

  always_comb begin
    ptr_next = ptr_reg;
    if (init || clr)
      ptr_next = beg_addr;
    else if (adv)
      ptr_next = wrapped[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_reg <= '0;
    else
      ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched
// Burst scheduler between the user read/write FIFOs and the AXI master
// engine. Decides when a write or read burst is due, round-robins on a tie,
// issues one command at a time and waits for the engine's done pulse.
// Optional macro DDR_BURST_SCHED_PERF_EN adds perf_wr_bursts, perf_rd_bursts
// and perf_wait_max counters.
// Ports:
//   clk, rst_n                   ui_clk, asynchronous active-low reset
//   calib_done                   DDR3 calibration done; gates new commands
//   wr_beg/end_addr, wr_burst_len write window and beats-1
//   rd_beg/end_addr, rd_burst_len read window and beats-1
//   rd_mem_enable                read gate
//   wr_addr_clr, rd_addr_clr     reload pointer to window start
//   wr_fifo_cnt, rd_fifo_space   FIFO levels in AXI words
//   cmd_valid/cmd_ready          command handshake
//   cmd_is_wr, cmd_addr, cmd_len command fields
//   cmd_done                     burst completion pulse from the engine
//   busy                         command outstanding
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int AXI_WIDTH = 64,
  parameter int ADDR_W    = 30,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic [ADDR_W-1:0] wr_beg_addr,
  input  logic [ADDR_W-1:0] wr_end_addr,
  input  logic [7:0]        wr_burst_len,
  input  logic [ADDR_W-1:0] rd_beg_addr,
  input  logic [ADDR_W-1:0] rd_end_addr,
  input  logic [7:0]        rd_burst_len,
  input  logic              rd_mem_enable,
  input  logic              wr_addr_clr,
  input  logic              rd_addr_clr,
  input  logic [CNT_W-1:0]  wr_fifo_cnt,
  input  logic [CNT_W-1:0]  rd_fifo_space,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_is_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              cmd_done,
`ifdef DDR_BURST_SCHED_PERF_EN
  output logic [31:0]       perf_wr_bursts,
  output logic [31:0]       perf_rd_bursts,
  output logic [15:0]       perf_wait_max,
`endif
  output logic              busy
);

  localparam int SHIFT = axi_shift(AXI_WIDTH);

  sched_state_t state_reg, state_next;

  logic              init_reg;
  logic              wr_req_reg, rd_req_reg;
  logic              rr_last_reg;   // 1: write was served last
  logic              cmd_is_wr_reg;
  logic [ADDR_W-1:0] cmd_addr_reg;
  logic [7:0]        cmd_len_reg;
  logic [CNT_W:0]    wr_need, rd_need;
  logic              win_wr;
  logic              start;
  logic              accept;

  // Channel 0 is write, channel 1 is read.
  logic [ADDR_W-1:0] ch_beg [2];
  logic [ADDR_W-1:0] ch_end [2];
  logic [ADDR_W-1:0] ch_ptr [2];
  logic              ch_clr [2];
  logic              ch_adv [2];

  // Burst size in words is compared one bit wider than the FIFO level so
  // that len+1 never truncates.
  assign wr_need = (CNT_W+1)'(wr_burst_len) + (CNT_W+1)'(1);
  assign rd_need = (CNT_W+1)'(rd_burst_len) + (CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_reg   <= 1'b1;
      wr_req_reg <= 1'b0;
      rd_req_reg <= 1'b0;
    end else begin
      init_reg   <= 1'b0;
      wr_req_reg <= calib_done & ({1'b0, wr_fifo_cnt} >= wr_need);
      rd_req_reg <= calib_done & rd_mem_enable & ({1'b0, rd_fifo_space} >= rd_need);
    end
  end

  // On a tie the channel not served last wins.
  assign win_wr = wr_req_reg & (~rd_req_reg | ~rr_last_reg);
  assign start  = (state_reg == IDLE) & (wr_req_reg | rd_req_reg);
  assign accept = (state_reg == ISSUE) & cmd_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wr_req_reg | rd_req_reg) state_next = ISSUE;
      ISSUE:   if (cmd_ready)               state_next = WAIT;
      WAIT:    if (cmd_done)                state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      ISSUE: begin
        cmd_valid = 1'b1;
        busy      = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: ;
    endcase
  end

  // Command fields are captured once on the way into ISSUE and held until
  // the next arbitration, so they stay stable across backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_is_wr_reg <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_len_reg   <= '0;
      rr_last_reg   <= 1'b0;
    end else begin
      if (start) begin
        cmd_is_wr_reg <= win_wr;
        cmd_addr_reg  <= win_wr ? ch_ptr[0] : ch_ptr[1];
        cmd_len_reg   <= win_wr ? wr_burst_len : rd_burst_len;
      end
      if (accept)
        rr_last_reg <= cmd_is_wr_reg;
    end
  end

  assign cmd_is_wr = cmd_is_wr_reg;
  assign cmd_addr  = cmd_addr_reg;
  assign cmd_len   = cmd_len_reg;

  assign ch_beg[0] = wr_beg_addr;
  assign ch_beg[1] = rd_beg_addr;
  assign ch_end[0] = wr_end_addr;
  assign ch_end[1] = rd_end_addr;
  assign ch_clr[0] = wr_addr_clr;
  assign ch_clr[1] = rd_addr_clr;
  assign ch_adv[0] = accept &  cmd_is_wr_reg;
  assign ch_adv[1] = accept & ~cmd_is_wr_reg;

  // The pointer steps by the length of the burst just accepted.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      ddr_addr_wrap #(
        .ADDR_W (ADDR_W),
        .SHIFT  (SHIFT)
      ) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init_reg),
        .clr       (ch_clr[gi]),
        .adv       (ch_adv[gi]),
        .beg_addr  (ch_beg[gi]),
        .end_addr  (ch_end[gi]),
        .burst_len (cmd_len_reg),
        .ptr       (ch_ptr[gi])
      );
    end
  endgenerate

`ifdef DDR_BURST_SCHED_PERF_EN
  logic [31:0] perf_wr_reg, perf_rd_reg;
  logic [15:0] wait_cnt_reg, wait_max_reg;
  logic [15:0] wait_cur;

  // Cycles spent in ISSUE and WAIT, counting the done cycle itself.
  assign wait_cur = (wait_cnt_reg == 16'hFFFF) ? 16'hFFFF : wait_cnt_reg + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wr_reg  <= '0;
      perf_rd_reg  <= '0;
      wait_cnt_reg <= '0;
      wait_max_reg <= '0;
    end else begin
      if (accept &  cmd_is_wr_reg) perf_wr_reg <= perf_wr_reg + 32'd1;
      if (accept & ~cmd_is_wr_reg) perf_rd_reg <= perf_rd_reg + 32'd1;
      if (state_reg == IDLE)
        wait_cnt_reg <= '0;
      else
        wait_cnt_reg <= wait_cur;
      if ((state_reg == WAIT) && cmd_done && (wait_cur > wait_max_reg))
        wait_max_reg <= wait_cur;
    end
  end

  assign perf_wr_bursts = perf_wr_reg;
  assign perf_rd_bursts = perf_rd_reg;
  assign perf_wait_max  = wait_max_reg;
`endif

endmodule

// File: tb/tb_ddr_burst_sched.sv
// tb_ddr_burst_sched
// Scoreboard bench for ddr_burst_sched: expected commands are queued as the
// FIFO levels are driven, and popped and compared as the DUT presents them.
// A small engine model drives cmd_ready/cmd_done with configurable delays.
module tb_ddr_burst_sched;

  localparam int ADDR_W = 30;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              calib_done;
  logic [ADDR_W-1:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
  logic [7:0]        wr_burst_len, rd_burst_len;
  logic              rd_mem_enable, wr_addr_clr, rd_addr_clr;
  logic [CNT_W-1:0]  wr_fifo_cnt, rd_fifo_space;
  logic              cmd_valid, cmd_ready, cmd_is_wr, cmd_done, busy;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
`ifdef DDR_BURST_SCHED_PERF_EN
  logic [31:0]       perf_wr_bursts, perf_rd_bursts;
  logic [15:0]       perf_wait_max;
`endif

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } exp_cmd_t;

  exp_cmd_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  ddr_burst_sched #(
    .AXI_WIDTH (64),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .calib_done    (calib_done),
    .wr_beg_addr   (wr_beg_addr),
    .wr_end_addr   (wr_end_addr),
    .wr_burst_len  (wr_burst_len),
    .rd_beg_addr   (rd_beg_addr),
    .rd_end_addr   (rd_end_addr),
    .rd_burst_len  (rd_burst_len),
    .rd_mem_enable (rd_mem_enable),
    .wr_addr_clr   (wr_addr_clr),
    .rd_addr_clr   (rd_addr_clr),
    .wr_fifo_cnt   (wr_fifo_cnt),
    .rd_fifo_space (rd_fifo_space),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_is_wr     (cmd_is_wr),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_done      (cmd_done),
`ifdef DDR_BURST_SCHED_PERF_EN
    .perf_wr_bursts(perf_wr_bursts),
    .perf_rd_bursts(perf_rd_bursts),
    .perf_wait_max (perf_wait_max),
`endif
    .busy          (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_wr, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    exp_cmd_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.len   = len;
    sb_q.push_back(e);
  endtask

  task automatic pulse_wr_clr();
    @(negedge clk);
    wr_addr_clr = 1'b1;
    @(negedge clk);
    wr_addr_clr = 1'b0;
  endtask

  // Bounded wait for cmd_valid, then compare it against the scoreboard head.
  task automatic take_cmd(output logic ok);
    exp_cmd_t e;
    int n;
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_valid;
    if (!cmd_valid) begin
      check_val("cmd_timeout", {63'd0, cmd_valid}, 64'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check_val("unexpected_cmd", {63'd0, cmd_valid}, 64'd0);
      ok = 1'b0;
      return;
    end
    e = sb_q.pop_front();
    n_txn++;
    $display("txn %0d: %s addr=0x%0h len=%0d (expected %s addr=0x%0h len=%0d)", n_txn,
             cmd_is_wr ? "WR" : "RD", cmd_addr, cmd_len, e.is_wr ? "WR" : "RD", e.addr, e.len);
    check_val("cmd_is_wr", {63'd0, cmd_is_wr}, {63'd0, e.is_wr});
    check_val("cmd_addr",  {34'd0, cmd_addr},  {34'd0, e.addr});
    check_val("cmd_len",   {56'd0, cmd_len},   {56'd0, e.len});
    check_val("busy_issue", {63'd0, busy}, 64'd1);
  endtask

  // Engine model for one command: backpressure, accept, optional write
  // pointer clear during WAIT, then completion pulse.
  task automatic serve(input int rdy_dly, input int done_dly, input logic last, input logic clr_wait);
    logic ok;
    logic [ADDR_W-1:0] a0;
    take_cmd(ok);
    if (!ok) return;
    a0 = cmd_addr;
    repeat (rdy_dly) begin
      @(negedge clk);
      check_val("hold_valid", {63'd0, cmd_valid}, 64'd1);
      check_val("hold_addr", {34'd0, cmd_addr}, {34'd0, a0});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_val("valid_drop", {63'd0, cmd_valid}, 64'd0);
    if (clr_wait) begin
      wr_addr_clr = 1'b1;
      @(negedge clk);
      wr_addr_clr = 1'b0;
    end
    repeat (done_dly) begin
      @(negedge clk);
      check_val("wait_no_new_cmd", {63'd0, cmd_valid}, 64'd0);
      check_val("wait_busy", {63'd0, busy}, 64'd1);
    end
    cmd_done = 1'b1;
    if (last) begin
      wr_fifo_cnt   = '0;
      rd_fifo_space = '0;
    end
    @(negedge clk);
    cmd_done = 1'b0;
    check_val("busy_drop", {63'd0, busy}, 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      seen = seen | cmd_valid | busy;
    end
    check_val(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst_n         = 1'b0;
    calib_done    = 1'b1;
    wr_beg_addr   = 30'h0;
    wr_end_addr   = 30'h3FF;
    wr_burst_len  = 8'd7;
    rd_beg_addr   = 30'h1000;
    rd_end_addr   = 30'h1FFF;
    rd_burst_len  = 8'd7;
    rd_mem_enable = 1'b1;
    wr_addr_clr   = 1'b0;
    rd_addr_clr   = 1'b0;
    wr_fifo_cnt   = '0;
    rd_fifo_space = '0;
    cmd_ready     = 1'b0;
    cmd_done      = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_cmd_is_wr", {63'd0, cmd_is_wr}, 64'd0);
    check_val("rst_cmd_addr", {34'd0, cmd_addr}, 64'd0);
    check_val("rst_cmd_len", {56'd0, cmd_len}, 64'd0);
    rst_n = 1'b1;
    watch_idle("idle_no_levels", 4);

    // Tie from reset: write first, then strict alternation.
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, ADDR_W'(i * 64), 8'd7);
      push_exp(1'b0, ADDR_W'(32'h1000 + i * 64), 8'd7);
    end
    wr_fifo_cnt   = 10'd8;
    rd_fifo_space = 10'd8;
    for (int k = 0; k < 6; k++) serve(0, 1, k == 5, 1'b0);
    watch_idle("idle_after_tie", 4);

    // Write only through a 1 KiB window: 16 bursts then wrap to 0.
    rd_mem_enable = 1'b0;
    pulse_wr_clr();
    for (int i = 0; i < 16; i++) push_exp(1'b1, ADDR_W'(i * 64), 8'd7);
    push_exp(1'b1, 30'h0, 8'd7);
    wr_fifo_cnt = 10'd8;
    for (int k = 0; k < 17; k++) serve(k % 3, k % 4, k == 16, 1'b0);

    // Gating: calibration low, then read disabled with write one word short.
    calib_done    = 1'b0;
    rd_mem_enable = 1'b1;
    wr_fifo_cnt   = 10'd8;
    rd_fifo_space = 10'd8;
    watch_idle("gate_calib", 20);
    wr_fifo_cnt   = 10'd7;
    rd_mem_enable = 1'b0;
    calib_done    = 1'b1;
    watch_idle("gate_level_rden", 20);

    // Handshake: 5 cycles of backpressure, long completion.
    pulse_wr_clr();
    push_exp(1'b1, 30'h0, 8'd7);
    wr_fifo_cnt = 10'd8;
    serve(5, 4, 1'b1, 1'b0);

    // Uneven window with a pointer clear while a write is in WAIT.
    wr_beg_addr = 30'h100;
    wr_end_addr = 30'h1BF;
    pulse_wr_clr();
    push_exp(1'b1, 30'h100, 8'd7);
    push_exp(1'b1, 30'h140, 8'd7);
    push_exp(1'b1, 30'h180, 8'd7);
    push_exp(1'b1, 30'h100, 8'd7);
    push_exp(1'b1, 30'h140, 8'd7);
    push_exp(1'b1, 30'h100, 8'd7);
    wr_fifo_cnt = 10'd8;
    for (int k = 0; k < 6; k++) serve(1, 2, k == 5, k == 4);

    // Reset while a write is in WAIT, then restart at the window start.
    push_exp(1'b1, 30'h140, 8'd7);
    wr_fifo_cnt = 10'd8;
    take_cmd(ok);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_val("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_val("mid_rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    check_val("mid_rst_cmd_addr", {34'd0, cmd_addr}, 64'd0);
    check_val("mid_rst_cmd_is_wr", {63'd0, cmd_is_wr}, 64'd0);
    check_val("mid_rst_cmd_len", {56'd0, cmd_len}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b1, 30'h100, 8'd7);
    serve(0, 1, 1'b1, 1'b0);

    watch_idle("idle_final", 6);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
